// File: rtl/fsmc_pkg.sv
// Shared types and helpers for the FSMC multiplexed-bus slave.
package fsmc_pkg;

   localparam int NUM_CH_DEF = 4;
   localparam int CH_W       = $clog2(NUM_CH_DEF);
   localparam int RD_LAT_MAX = 4;
   localparam int CS_MAX     = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WAIT,
      ST_WRITE,
      ST_READ
   } fsmc_state_t;

   // Channel indices at or above num_ch decode to an all-zero select.
   function automatic logic [CS_MAX-1:0] onehot_cs(input logic [7:0] idx, input int num_ch);
      logic [CS_MAX-1:0] v;
      v = '0;
      if (int'(idx) < num_ch) v[idx[4:0]] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/fsmc_sync.sv
// Multi-stage synchroniser with rise/fall detection on the synchronised value.
module fsmc_sync #(
   parameter int   W       = 1,
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q,
   output logic [W-1:0] o_rise,
   output logic [W-1:0] o_fall
);

   logic [W-1:0] r_pipe [STAGES];
   logic [W-1:0] r_prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) r_pipe[i] <= {W{RST_VAL}};
         r_prev <= {W{RST_VAL}};
      end else begin
         r_pipe[0] <= i_d;
         for (int i = 1; i < STAGES; i++) r_pipe[i] <= r_pipe[i-1];
         r_prev <= r_pipe[STAGES-1];
      end
   end

   assign o_q    = r_pipe[STAGES-1];
   assign o_rise = o_q & ~r_prev;
   assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/fsmc_mux_slave.sv
// FSMC multiplexed AD-bus slave: burst auto-increment, per-channel read mux, abort.
// Optional read prefetch enabled by defining FSMC_RD_PREFETCH_EN.
module fsmc_mux_slave
   import fsmc_pkg::*;
#(
   parameter int AD_W        = 18,
   parameter int DW          = 16,
   parameter int NUM_CH      = 4,
   parameter int CH_LSB      = 16,
   parameter int RD_LAT      = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 NADV,
   input  logic                 NWE,
   input  logic                 NOE,
   inout  wire  [AD_W-1:0]      AD,
   output logic [CH_LSB-1:0]    addr,
   output logic [NUM_CH-1:0]    cs,
   output logic                 addr_en,
   output logic                 wr_en,
   output logic [DW-1:0]        wr_data,
   output logic                 rd_en,
   input  logic [NUM_CH*DW-1:0] rd_data,
   output logic                 busy
);

   localparam int L_CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int L_RD_LAT = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : ((RD_LAT < 1) ? 1 : RD_LAT);
   localparam int L_SYNC   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   logic w_nadv_s, w_nadv_rise, w_nadv_fall;
   logic w_nwe_s, w_nwe_rise, w_nwe_fall_unused;
   logic w_noe_s, w_noe_rise, w_noe_fall_unused;
   logic [AD_W-1:0] w_ad_s, w_ad_rise_unused, w_ad_fall_unused;

   // AD runs through the same depth as the strobes so data stays aligned with them.
   fsmc_sync #(.W(1), .STAGES(L_SYNC), .RST_VAL(1'b1)) u_sync_nadv (
      .clk(clk), .reset(reset), .i_d(NADV), .o_q(w_nadv_s), .o_rise(w_nadv_rise), .o_fall(w_nadv_fall));
   fsmc_sync #(.W(1), .STAGES(L_SYNC), .RST_VAL(1'b1)) u_sync_nwe (
      .clk(clk), .reset(reset), .i_d(NWE), .o_q(w_nwe_s), .o_rise(w_nwe_rise), .o_fall(w_nwe_fall_unused));
   fsmc_sync #(.W(1), .STAGES(L_SYNC), .RST_VAL(1'b1)) u_sync_noe (
      .clk(clk), .reset(reset), .i_d(NOE), .o_q(w_noe_s), .o_rise(w_noe_rise), .o_fall(w_noe_fall_unused));
   fsmc_sync #(.W(AD_W), .STAGES(L_SYNC), .RST_VAL(1'b0)) u_sync_ad (
      .clk(clk), .reset(reset), .i_d(AD), .o_q(w_ad_s), .o_rise(w_ad_rise_unused), .o_fall(w_ad_fall_unused));

   fsmc_state_t         r_state;
   logic [CH_LSB-1:0]   r_addr;
   logic [NUM_CH-1:0]   r_cs;
   logic [L_CH_W-1:0]   r_ch;
   logic                r_ch_bad;
   logic [AD_W-1:0]     r_ad_cap;
   logic [DW-1:0]       r_wd_cap;
   logic [DW-1:0]       r_wr_data;
   logic                r_wr_en, r_rd_en, r_addr_en, r_inc_pend;
   logic [L_RD_LAT-1:0] r_lat_sr;
   logic [DW-1:0]       r_ad_out;
`ifdef FSMC_RD_PREFETCH_EN
   logic                r_pf_valid;
`endif

   logic [L_CH_W-1:0] w_ch_new;
   logic [NUM_CH-1:0] w_cs_new;
   logic [DW-1:0]     w_rd_slice;
   logic              w_oe;

   assign w_ch_new = r_ad_cap[CH_LSB +: L_CH_W];
   assign w_cs_new = NUM_CH'(onehot_cs(8'(w_ch_new), NUM_CH));

   always_comb begin
      w_rd_slice = '0;
      for (int k = 0; k < NUM_CH; k++)
         if (int'(r_ch) == k) w_rd_slice = rd_data[k*DW +: DW];
   end

   // Released combinationally on the detecting cycle so the MCU gets the bus back without delay.
   assign w_oe = (r_state == ST_READ) && !w_noe_rise && !w_nadv_fall;
   assign AD   = w_oe ? AD_W'(r_ad_out) : 'z;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_addr     <= '0;
         r_cs       <= '0;
         r_ch       <= '0;
         r_ch_bad   <= 1'b0;
         r_ad_cap   <= '0;
         r_wd_cap   <= '0;
         r_wr_data  <= '0;
         r_wr_en    <= 1'b0;
         r_rd_en    <= 1'b0;
         r_addr_en  <= 1'b0;
         r_inc_pend <= 1'b0;
`ifdef FSMC_RD_PREFETCH_EN
         r_pf_valid <= 1'b0;
`endif
      end else begin
         r_addr_en <= 1'b0;
         r_wr_en   <= 1'b0;
         r_rd_en   <= 1'b0;
         case (r_state)
            ST_IDLE: if (!w_nadv_s) begin
               r_ad_cap <= w_ad_s;
               r_state  <= ST_ADDR;
            end
            ST_ADDR: begin
               if (w_nadv_rise) begin
                  r_addr    <= r_ad_cap[CH_LSB-1:0];
                  r_ch      <= w_ch_new;
                  r_cs      <= w_cs_new;
                  r_ch_bad  <= (w_cs_new == '0);
                  r_addr_en <= 1'b1;
`ifdef FSMC_RD_PREFETCH_EN
                  r_rd_en    <= 1'b1;
                  r_pf_valid <= 1'b1;
`endif
                  r_state   <= ST_WAIT;
               end else if (!w_nadv_s) begin
                  r_ad_cap <= w_ad_s;
               end
            end
            ST_WAIT: begin
               if (!w_nadv_s) begin
                  r_ad_cap <= w_ad_s;
                  r_state  <= ST_ADDR;
               end else if (!w_nwe_s) begin
                  r_wd_cap <= w_ad_s[DW-1:0];
                  r_state  <= ST_WRITE;
               end else if (!w_noe_s) begin
`ifdef FSMC_RD_PREFETCH_EN
                  r_rd_en <= !r_pf_valid;
`else
                  r_rd_en <= 1'b1;
`endif
                  r_state <= ST_READ;
               end
            end
            ST_WRITE: begin
               if (w_nadv_fall) begin
                  r_ad_cap   <= w_ad_s;
                  r_inc_pend <= 1'b0;
                  r_state    <= ST_ADDR;
               end else if (r_inc_pend) begin
                  r_addr     <= r_addr + CH_LSB'(1);
                  r_inc_pend <= 1'b0;
                  r_state    <= ST_WAIT;
               end else if (w_nwe_rise) begin
                  r_wr_en    <= !r_ch_bad;
                  if (!r_ch_bad) r_wr_data <= r_wd_cap;
                  r_inc_pend <= 1'b1;
`ifdef FSMC_RD_PREFETCH_EN
                  r_pf_valid <= 1'b0;
`endif
               end else if (!w_nwe_s) begin
                  r_wd_cap <= w_ad_s[DW-1:0];
               end
            end
            ST_READ: begin
               if (w_nadv_fall) begin
                  r_ad_cap <= w_ad_s;
                  r_state  <= ST_ADDR;
               end else if (w_noe_rise) begin
                  r_addr  <= r_addr + CH_LSB'(1);
`ifdef FSMC_RD_PREFETCH_EN
                  r_rd_en    <= 1'b1;
                  r_pf_valid <= 1'b1;
`endif
                  r_state <= ST_WAIT;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Read data lands in the AD output register L_RD_LAT cycles after rd_en.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lat_sr <= '0;
         r_ad_out <= '0;
      end else begin
         r_lat_sr <= (r_lat_sr << 1) | L_RD_LAT'(r_rd_en);
         if (r_lat_sr[L_RD_LAT-1]) r_ad_out <= w_rd_slice;
      end
   end

   assign addr    = r_addr;
   assign cs      = r_cs;
   assign addr_en = r_addr_en;
   assign wr_en   = r_wr_en;
   assign wr_data = r_wr_data;
   assign rd_en   = r_rd_en;
   assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fsmc_mux_slave.sv
// Directed bench for fsmc_mux_slave: single/burst writes, reads, collisions, abort, reset.
module tb_fsmc_mux_slave;

   localparam int AD_W   = 18;
   localparam int DW     = 16;
   localparam int NUM_CH = 4;
   localparam int CH_LSB = 16;

   logic clk = 1'b0;
   logic reset;
   logic NADV, NWE, NOE;
   wire  [AD_W-1:0] AD;
   logic [AD_W-1:0] tb_ad_drv;
   logic            tb_ad_oe;
   logic [CH_LSB-1:0]    addr;
   logic [NUM_CH-1:0]    cs;
   logic                 addr_en, wr_en, rd_en, busy;
   logic [DW-1:0]        wr_data;
   logic [NUM_CH*DW-1:0] rd_data;

   int vectors     = 0;
   int miscompares = 0;
   int wr_cnt      = 0;
   int rd_cnt      = 0;
   int aen_cnt     = 0;
   int oe_cycles   = 0;
   int oe_base;
   logic [CH_LSB+DW-1:0] exp_q[$];

   assign AD = tb_ad_oe ? tb_ad_drv : 'z;
   assign rd_data = {16'h3333, 16'h2222, 16'hFF00, 16'h1111};

   fsmc_mux_slave #(
      .AD_W(AD_W), .DW(DW), .NUM_CH(NUM_CH), .CH_LSB(CH_LSB), .RD_LAT(1), .SYNC_STAGES(2)
   ) dut (
      .clk(clk), .reset(reset), .NADV(NADV), .NWE(NWE), .NOE(NOE), .AD(AD),
      .addr(addr), .cs(cs), .addr_en(addr_en), .wr_en(wr_en), .wr_data(wr_data),
      .rd_en(rd_en), .rd_data(rd_data), .busy(busy)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // driver tasks
   task automatic mcu_addr(input logic [AD_W-1:0] a);
      tb_ad_drv = a;
      tb_ad_oe  = 1'b1;
      NADV      = 1'b0;
      cyc(4);
      NADV      = 1'b1;
      cyc(5);
   endtask

   task automatic wr_stroke(input logic [DW-1:0] d);
      tb_ad_drv = AD_W'(d);
      tb_ad_oe  = 1'b1;
      NWE       = 1'b0;
      cyc(4);
      NWE       = 1'b1;
      cyc(5);
   endtask

   // scoreboard and pulse monitors
   always @(negedge clk) begin
      if (addr_en) aen_cnt++;
      if (rd_en) rd_cnt++;
      if (dut.w_oe) oe_cycles++;
      if (wr_en) begin
         wr_cnt++;
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL wr_unexpected: observed addr %0h data %0h expected no write", addr, wr_data);
         end else begin
            check("wr_sb", 32'({addr, wr_data}), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      reset = 1'b1; NADV = 1'b1; NWE = 1'b1; NOE = 1'b1;
      tb_ad_oe = 1'b1; tb_ad_drv = '0;
      cyc(3);
      check("rst_addr", 32'(addr), 32'h0);
      check("rst_cs", 32'(cs), 32'h0);
      check("rst_wr_data", 32'(wr_data), 32'h0);
      check("rst_pulses", {29'h0, addr_en, wr_en, rd_en}, 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_oe", 32'(dut.w_oe), 32'h0);
      reset = 1'b0;
      cyc(2);

      // single read, channel 1 offset 5
      mcu_addr(18'h10005);
      check("rd_addr", 32'(addr), 32'h5);
      check("rd_cs", 32'(cs), 32'h2);
      check("rd_aen", aen_cnt, 1);
      check("rd_busy_wait", 32'(busy), 32'h1);
      tb_ad_oe = 1'b0;
      NOE      = 1'b0;
      cyc(6);
      check("rd_oe", 32'(dut.w_oe), 32'h1);
      check("rd_ad", 32'(AD), 32'h0FF00);
      check("rd_cnt", rd_cnt, 1);
      NOE = 1'b1;
      cyc(5);
      check("rd_release", 32'(dut.w_oe), 32'h0);
      check("rd_inc", 32'(addr), 32'h6);

      // single write, channel 0 offset 0
      oe_base = oe_cycles;
      mcu_addr(18'h00000);
      check("wr_addr", 32'(addr), 32'h0);
      check("wr_cs", 32'(cs), 32'h1);
      check("wr_aen", aen_cnt, 2);
      exp_q.push_back({16'h0000, 16'h1234});
      wr_stroke(16'h1234);
      check("wr_cnt", wr_cnt, 1);
      check("wr_data", 32'(wr_data), 32'h1234);
      check("wr_inc", 32'(addr), 32'h1);

      // burst write across the offset wrap, channel 2
      mcu_addr(18'h2FFFE);
      check("bw_addr", 32'(addr), 32'hFFFE);
      exp_q.push_back({16'hFFFE, 16'hAAAA});
      exp_q.push_back({16'hFFFF, 16'hBBBB});
      exp_q.push_back({16'h0000, 16'hCCCC});
      wr_stroke(16'hAAAA);
      check("bw_cs0", 32'(cs), 32'h4);
      wr_stroke(16'hBBBB);
      check("bw_cs1", 32'(cs), 32'h4);
      wr_stroke(16'hCCCC);
      check("bw_cs2", 32'(cs), 32'h4);
      check("bw_wrap_addr", 32'(addr), 32'h1);
      check("bw_cnt", wr_cnt, 4);
      check("bw_no_rd", rd_cnt, 1);

      // NWE and NOE fall together: write wins
      mcu_addr(18'h00010);
      exp_q.push_back({16'h0010, 16'h5A5A});
      tb_ad_drv = 18'h05A5A;
      NWE = 1'b0;
      NOE = 1'b0;
      cyc(4);
      NWE = 1'b1;
      NOE = 1'b1;
      cyc(5);
      check("col_wr_cnt", wr_cnt, 5);
      check("col_rd_cnt", rd_cnt, 1);
      check("col_wr_data", 32'(wr_data), 32'h5A5A);
      check("wr_never_drove_ad", oe_cycles, oe_base);

      // NADV re-asserted mid-read
      mcu_addr(18'h10020);
      tb_ad_oe = 1'b0;
      NOE      = 1'b0;
      cyc(6);
      check("ab_oe", 32'(dut.w_oe), 32'h1);
      check("ab_ad", 32'(AD), 32'h0FF00);
      check("ab_rd_cnt", rd_cnt, 2);
      tb_ad_drv = 18'h30007;
      tb_ad_oe  = 1'b1;
      NOE       = 1'b1;
      NADV      = 1'b0;
      cyc(4);
      check("ab_release", 32'(dut.w_oe), 32'h0);
      check("ab_no_inc", 32'(addr), 32'h20);
      NADV = 1'b1;
      cyc(5);
      check("ab_new_addr", 32'(addr), 32'h7);
      check("ab_new_cs", 32'(cs), 32'h8);
      check("ab_aen", aen_cnt, 6);
      check("ab_rd_after", rd_cnt, 2);
      check("ab_wr_after", wr_cnt, 5);

      // reset pulsed while NWE is low
      mcu_addr(18'h00040);
      tb_ad_drv = 18'h07777;
      NWE = 1'b0;
      cyc(4);
      check("rw_busy", 32'(busy), 32'h1);
      reset = 1'b1;
      #1;
      check("rw_addr", 32'(addr), 32'h0);
      check("rw_cs", 32'(cs), 32'h0);
      check("rw_wr_data", 32'(wr_data), 32'h0);
      check("rw_busy0", 32'(busy), 32'h0);
      check("rw_oe", 32'(dut.w_oe), 32'h0);
      cyc(2);
      reset = 1'b0;
      cyc(3);
      NWE = 1'b1;
      cyc(6);
      check("rw_no_wr", wr_cnt, 5);
      check("rw_idle", 32'(busy), 32'h0);
      mcu_addr(18'h10003);
      exp_q.push_back({16'h0003, 16'hBEEF});
      wr_stroke(16'hBEEF);
      check("rw_next_cnt", wr_cnt, 6);
      check("rw_next_cs", 32'(cs), 32'h2);
      check("rw_next_addr", 32'(addr), 32'h4);
      check("sb_drained", exp_q.size(), 0);

      // final report
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
